// File: rtl/iob_reg_rr_arbiter_pkg.sv
// Shared definitions for the registered round-robin arbiter: FSM encoding and index helpers.
package iob_reg_rr_arbiter_pkg;

    typedef enum logic [1:0] {
        EMPTY  = 2'd0,
        FULL   = 2'd1,
        LOCKED = 2'd2
    } state_t;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int k = 0; k < 32; k++) begin
            if ((1 << r) < n) r++;
        end
        return r;
    endfunction

    // Callers guarantee at most one bit is set.
    function automatic logic [3:0] onehot2bin(input logic [15:0] oh);
        logic [3:0] b;
        b = '0;
        for (int k = 0; k < 16; k++) begin
            if (oh[k]) b = b | 4'(k);
        end
        return b;
    endfunction

endpackage

// File: rtl/iob_reg_r.sv
// Register primitive with clock enable and synchronous soft reset over an async active-low reset.
module iob_reg_r #(
    parameter int                DATA_W  = 1,
    parameter logic [DATA_W-1:0] RST_VAL = '0
) (
    input  logic              clk_i,
    input  logic              arst_n_i,
    input  logic              cke_i,
    input  logic              rst_i,
    input  logic [DATA_W-1:0] data_i,
    output logic [DATA_W-1:0] data_o
);

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            data_o <= RST_VAL;
        end else if (cke_i) begin
            data_o <= rst_i ? RST_VAL : data_i;
        end
    end

endmodule

// File: rtl/iob_rr_pick.sv
// Circular priority finder: first set bit of req strictly after ptr, wrapping to index 0.
module iob_rr_pick
    import iob_reg_rr_arbiter_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int IDX_W = clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [IDX_W-1:0] idx,
    output logic             found
);

    logic [IDX_W-1:0] hi_idx, lo_idx;
    logic             hi_found, lo_found;

    // Scan downward so the lowest qualifying index is the one left standing.
    always_comb begin
        hi_idx   = '0;
        lo_idx   = '0;
        hi_found = 1'b0;
        lo_found = 1'b0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (req[k] && (k > int'(ptr))) begin
                hi_found = 1'b1;
                hi_idx   = IDX_W'(k);
            end
            if (req[k] && (k <= int'(ptr))) begin
                lo_found = 1'b1;
                lo_idx   = IDX_W'(k);
            end
        end
        found = hi_found | lo_found;
        idx   = hi_found ? hi_idx : lo_idx;
    end

endmodule

// File: rtl/iob_reg_rr_arbiter.sv
// Round-robin arbiter feeding one registered output stage; requester locking is built
// only when IOB_REG_RR_ARBITER_LOCK_EN is defined.
module iob_reg_rr_arbiter
    import iob_reg_rr_arbiter_pkg::*;
#(
    parameter int N_REQ  = 4,
    parameter int DATA_W = 32,
    parameter int ID_W   = 2
) (
    input  logic                    clk_i,
    input  logic                    arst_n_i,
    input  logic                    cke_i,
    input  logic                    rst_i,
    input  logic [N_REQ-1:0]        req_valid_i,
    input  logic [N_REQ*DATA_W-1:0] req_data_i,
`ifdef IOB_REG_RR_ARBITER_LOCK_EN
    input  logic [N_REQ-1:0]        req_lock_i,
`endif
    output logic [N_REQ-1:0]        req_ready_o,
    output logic                    out_valid_o,
    output logic [DATA_W-1:0]       out_data_o,
    output logic [ID_W-1:0]         out_id_o,
    input  logic                    out_ready_i,
    output logic [N_REQ-1:0]        grant_o
);

    state_t             state_q, state_d;
    logic [1:0]         state_bits;
    logic [ID_W-1:0]    ptr_q, ptr_d, win_idx, acc_idx, id_d;
    logic               found, can_accept, accept, drain, valid_d;
    logic [N_REQ-1:0]   eligible, hs, grant_d;
    logic [15:0]        hs_ext;
    logic [DATA_W-1:0]  data_sel, data_d;

`ifdef IOB_REG_RR_ARBITER_LOCK_EN
    logic               lock_q, lock_d;
    logic [ID_W-1:0]    owner_q, owner_d;

    // A held lock restricts the search to its owner, even after the stage drains.
    assign eligible = lock_q ? (req_valid_i & (N_REQ'(1) << owner_q)) : req_valid_i;
`else
    assign eligible = req_valid_i;
`endif

    assign state_q = state_t'(state_bits);

    iob_rr_pick #(
        .N_REQ (N_REQ),
        .IDX_W (ID_W)
    ) u_pick (
        .req   (eligible),
        .ptr   (ptr_q),
        .idx   (win_idx),
        .found (found)
    );

    assign can_accept  = cke_i & ((state_q == EMPTY) | out_ready_i);
    assign req_ready_o = (can_accept & found) ? (N_REQ'(1) << win_idx) : '0;
    assign hs          = req_valid_i & req_ready_o;
    assign accept      = |hs;
    assign drain       = (state_q != EMPTY) & out_ready_i;

    always_comb begin
        hs_ext             = '0;
        hs_ext[N_REQ-1:0]  = hs;
        acc_idx            = ID_W'(onehot2bin(hs_ext));
        data_sel           = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (hs[k]) data_sel = req_data_i[k*DATA_W +: DATA_W];
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        valid_d = out_valid_o;
        data_d  = out_data_o;
        id_d    = out_id_o;
        grant_d = grant_o;
`ifdef IOB_REG_RR_ARBITER_LOCK_EN
        lock_d  = lock_q;
        owner_d = owner_q;
`endif
        if (accept) begin
            valid_d = 1'b1;
            data_d  = data_sel;
            id_d    = acc_idx;
            ptr_d   = acc_idx;
            grant_d = hs;
            state_d = FULL;
`ifdef IOB_REG_RR_ARBITER_LOCK_EN
            lock_d  = req_lock_i[acc_idx];
            owner_d = acc_idx;
            if (req_lock_i[acc_idx]) state_d = LOCKED;
`endif
        end else if (drain) begin
            valid_d = 1'b0;
            state_d = EMPTY;
        end
    end

    iob_reg_r #(.DATA_W(2), .RST_VAL(2'(EMPTY))) u_state_reg (
        .clk_i(clk_i), .arst_n_i(arst_n_i), .cke_i(cke_i), .rst_i(rst_i),
        .data_i(state_d), .data_o(state_bits));

    // Pointer resets to the last index so requester 0 wins the first search.
    iob_reg_r #(.DATA_W(ID_W), .RST_VAL(ID_W'(N_REQ - 1))) u_ptr_reg (
        .clk_i(clk_i), .arst_n_i(arst_n_i), .cke_i(cke_i), .rst_i(rst_i),
        .data_i(ptr_d), .data_o(ptr_q));

    iob_reg_r #(.DATA_W(1)) u_valid_reg (
        .clk_i(clk_i), .arst_n_i(arst_n_i), .cke_i(cke_i), .rst_i(rst_i),
        .data_i(valid_d), .data_o(out_valid_o));

    iob_reg_r #(.DATA_W(DATA_W)) u_data_reg (
        .clk_i(clk_i), .arst_n_i(arst_n_i), .cke_i(cke_i), .rst_i(rst_i),
        .data_i(data_d), .data_o(out_data_o));

    iob_reg_r #(.DATA_W(ID_W)) u_id_reg (
        .clk_i(clk_i), .arst_n_i(arst_n_i), .cke_i(cke_i), .rst_i(rst_i),
        .data_i(id_d), .data_o(out_id_o));

    iob_reg_r #(.DATA_W(N_REQ)) u_grant_reg (
        .clk_i(clk_i), .arst_n_i(arst_n_i), .cke_i(cke_i), .rst_i(rst_i),
        .data_i(grant_d), .data_o(grant_o));

`ifdef IOB_REG_RR_ARBITER_LOCK_EN
    iob_reg_r #(.DATA_W(1)) u_lock_reg (
        .clk_i(clk_i), .arst_n_i(arst_n_i), .cke_i(cke_i), .rst_i(rst_i),
        .data_i(lock_d), .data_o(lock_q));

    iob_reg_r #(.DATA_W(ID_W)) u_owner_reg (
        .clk_i(clk_i), .arst_n_i(arst_n_i), .cke_i(cke_i), .rst_i(rst_i),
        .data_i(owner_d), .data_o(owner_q));
`endif

endmodule

// File: tb/tb_iob_reg_rr_arbiter.sv
// Randomised and directed bench for iob_reg_rr_arbiter against a behavioural arbitration model.
module tb_iob_reg_rr_arbiter;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int IW = 2;

    logic            clk = 1'b0;
    logic            arst_n, cke, rst, out_ready;
    logic [N-1:0]    req_valid, req_ready, grant;
    logic [N*DW-1:0] req_data;
    logic            out_valid;
    logic [DW-1:0]   out_data;
    logic [IW-1:0]   out_id;
`ifdef IOB_REG_RR_ARBITER_LOCK_EN
    logic [N-1:0]    req_lock;
`endif

    int n_checks = 0;
    int n_errors = 0;

    // Model: last granted index, held beat, one-hot grant and optional lock.
    int m_ptr, m_data, m_id, m_grant, m_own;
    bit m_valid, m_lock;

    always #5 clk = ~clk;

    iob_reg_rr_arbiter #(.N_REQ(N), .DATA_W(DW), .ID_W(IW)) dut (
        .clk_i       (clk),
        .arst_n_i    (arst_n),
        .cke_i       (cke),
        .rst_i       (rst),
        .req_valid_i (req_valid),
        .req_data_i  (req_data),
`ifdef IOB_REG_RR_ARBITER_LOCK_EN
        .req_lock_i  (req_lock),
`endif
        .req_ready_o (req_ready),
        .out_valid_o (out_valid),
        .out_data_o  (out_data),
        .out_id_o    (out_id),
        .out_ready_i (out_ready),
        .grant_o     (grant)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_ptr   = N - 1;
        m_valid = 1'b0;
        m_data  = 0;
        m_id    = 0;
        m_grant = 0;
        m_lock  = 1'b0;
        m_own   = 0;
    endtask

    function automatic int model_winner();
        if (!cke) return -1;
        if (m_valid && !out_ready) return -1;
        for (int i = 1; i <= N; i++) begin
            int k;
            k = (m_ptr + i) % N;
            if (req_valid[k] && (!m_lock || k == m_own)) return k;
        end
        return -1;
    endfunction

    // Called at a negedge with inputs already applied; returns at the next negedge.
    task automatic cycle(input string tag);
        int w;
        logic [N-1:0] exp_ready;
        #1;
        w = model_winner();
        exp_ready = '0;
        if (w >= 0) exp_ready[w] = 1'b1;
        check({tag, ".ready"}, 32'(req_ready), 32'(exp_ready));
        @(posedge clk);
        if (cke) begin
            if (rst) begin
                model_reset();
            end else if (w >= 0) begin
                m_valid = 1'b1;
                m_data  = int'(req_data[w*DW +: DW]);
                m_id    = w;
                m_ptr   = w;
                m_grant = 1 << w;
`ifdef IOB_REG_RR_ARBITER_LOCK_EN
                m_lock  = req_lock[w];
                m_own   = w;
`endif
            end else if (m_valid && out_ready) begin
                m_valid = 1'b0;
            end
        end
        #1;
        check({tag, ".valid"}, 32'(out_valid), 32'(m_valid));
        check({tag, ".data"},  32'(out_data),  m_data);
        check({tag, ".id"},    32'(out_id),    m_id);
        check({tag, ".grant"}, 32'(grant),     m_grant);
        @(negedge clk);
    endtask

    initial begin
        arst_n    = 1'b0;
        cke       = 1'b1;
        rst       = 1'b0;
        out_ready = 1'b1;
        req_valid = '0;
        req_data  = '0;
`ifdef IOB_REG_RR_ARBITER_LOCK_EN
        req_lock  = '0;
`endif
        model_reset();
        repeat (2) @(negedge clk);
        check("rst.valid", 32'(out_valid), 0);
        check("rst.grant", 32'(grant), 0);
        check("rst.ready", 32'(req_ready), 0);
        arst_n = 1'b1;
        cycle("idle");
        check("idle.valid", 32'(out_valid), 0);

        // Rotation with everyone requesting.
        req_valid = 4'b1111;
        req_data  = {8'h13, 8'h12, 8'h11, 8'h10};
        for (int i = 0; i < 5; i++) begin
            cycle("rot");
            check("rot.id_seq", 32'(out_id), i % 4);
            check("rot.data_seq", 32'(out_data), 32'h10 + (i % 4));
        end

        // Backpressure holds the captured beat.
        req_valid = 4'b0100;
        req_data  = {8'h13, 8'hA2, 8'h11, 8'h10};
        cycle("bp_acc");
        check("bp.id", 32'(out_id), 2);
        out_ready = 1'b0;
        req_valid = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            cycle("bp_hold");
            check("bp.data", 32'(out_data), 32'hA2);
            check("bp.valid", 32'(out_valid), 1);
            check("bp.ready", 32'(req_ready), 0);
        end
        out_ready = 1'b1;
        cycle("bp_rel");
        check("bp.next_id", 32'(out_id), 3);

        // Pointer at 3 wraps to 0.
        req_valid = 4'b0101;
        cycle("wrap0");
        check("wrap.id0", 32'(out_id), 0);
        cycle("wrap1");
        check("wrap.id1", 32'(out_id), 2);

        // Clock enable freeze, then soft reset drops the held beat.
        cke = 1'b0;
        req_valid = 4'b1111;
        for (int i = 0; i < 3; i++) begin
            cycle("cke");
            check("cke.id", 32'(out_id), 2);
            check("cke.valid", 32'(out_valid), 1);
        end
        cke = 1'b1;
        rst = 1'b1;
        cycle("srst");
        check("srst.valid", 32'(out_valid), 0);
        rst = 1'b0;

`ifdef IOB_REG_RR_ARBITER_LOCK_EN
        req_valid = 4'b0001;
        cycle("lk_pre");
        check("lk.pre_id", 32'(out_id), 0);
        req_valid = 4'b1111;
        req_lock  = 4'b0010;
        cycle("lk1");
        check("lk.id1", 32'(out_id), 1);
        cycle("lk2");
        check("lk.id2", 32'(out_id), 1);
        req_lock  = 4'b0000;
        cycle("lk3");
        check("lk.id3", 32'(out_id), 1);
        for (int i = 0; i < 3; i++) begin
            cycle("lk_rr");
            check("lk.rr_id", 32'(out_id), (2 + i) % 4);
        end
`endif

        for (int i = 0; i < 400; i++) begin
            req_valid = N'($urandom);
            req_data  = $urandom;
            out_ready = ($urandom_range(0, 3) != 0);
            cke       = ($urandom_range(0, 7) != 0);
            rst       = ($urandom_range(0, 31) == 0);
`ifdef IOB_REG_RR_ARBITER_LOCK_EN
            req_lock  = N'($urandom & $urandom & $urandom);
`endif
            cycle("rnd");
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/iob_reg_rr_arbiter.md
Name: iob_reg_rr_arbiter

Overview:
- Round-robin arbiter that shares one registered output stage between N_REQ valid/ready requesters.
- Typical downstream is a single-write-port resource (register bank, cache write-back port).
- The winner's data and ID are captured into an output register and held until the downstream accepts.
- Includes a clock enable and a synchronous soft reset, matching the team's register primitives.

Parameters:
- N_REQ, 4: number of requesters, 2..16.
- DATA_W, 32: payload width per requester.
- ID_W, 2: width of the winner index; must satisfy ID_W = clog2(N_REQ).

Ports:
- clk_i  input  1  system clock, rising edge.
- arst_n_i  input  1  asynchronous reset, active-low.
- cke_i  input  1  clock enable; when 0, all state holds.
- rst_i  input  1  synchronous soft reset, active-high, qualified by cke_i.
- req_valid_i  input  N_REQ  per-requester valid.
- req_data_i  input  N_REQ*DATA_W  packed payloads; requester k occupies bits [k*DATA_W +: DATA_W].
- req_ready_o  output  N_REQ  per-requester ready; one-hot or zero.
- out_valid_o  output  1  output stage holds a beat.
- out_data_o  output  DATA_W  captured payload.
- out_id_o  output  ID_W  index of the captured requester.
- out_ready_i  input  1  downstream accepts the beat.
- grant_o  output  N_REQ  one-hot copy of the last accepted requester.

Behaviour:
- Reset (arst_n_i=0, or rst_i=1 with cke_i=1):
  - out_valid_o=0, out_data_o=0, out_id_o=0, grant_o=0.
  - Round-robin pointer = N_REQ-1, so requester 0 has first priority.
  - FSM goes to EMPTY.
- FSM state EMPTY (output stage empty):
  - Winner = first k with req_valid_i[k]=1, searching circularly from pointer+1.
  - req_ready_o[winner]=1; all other ready bits are 0.
  - If a winner exists, the FSM goes to FULL.
- FSM state FULL (output stage holds a beat):
  - If out_ready_i=1, the output is drained. In the same cycle a new winner is chosen as in EMPTY and is given ready.
  - Drain with a winner: stay in FULL.
  - Drain with no winner: go to EMPTY.
  - If out_ready_i=0: all req_ready_o=0; the output holds stable (data, id and valid unchanged).
- Accept: a handshake occurs when req_valid_i[k] & req_ready_o[k]. On that edge:
  - out_data_o <= req_data_i[k], out_id_o <= k, out_valid_o <= 1.
  - pointer <= k, grant_o <= one-hot(k).
- Latency: a beat accepted at edge t appears on the outputs after edge t. Sustained throughput is 1 beat/cycle while out_ready_i=1.
- req_ready_o is combinational from req_valid_i, the pointer, the state and out_ready_i. It has no combinational dependence on req_data_i.
- Fairness: with all N requesters continuously valid and out_ready_i=1, grants rotate 0,1,...,N-1,0,... and each requester waits at most N-1 beats.
- Pointer wrap: pointer N_REQ-1 wraps so the search starts at index 0.
- cke_i=0: no state changes and req_ready_o=0 (no handshakes). out_* keep their values.
- A requester dropping valid without a handshake is legal; the arbiter keeps no memory of it.
- Soft reset mid-transfer discards a held beat; a handshake in the same cycle is discarded too.
- rst_i takes priority over all handshakes.

Optional Feature:
- Macro: IOB_REG_RR_ARBITER_LOCK_EN.
- Defined:
  - Adds input port req_lock_i [N_REQ] and FSM state LOCKED.
  - A handshake with req_lock_i[k]=1 sets lock owner = k and enters LOCKED. The state is still FULL-like with respect to the output stage.
  - While LOCKED, only requester k can receive ready, under the same out_ready_i rules; other requesters are starved.
  - A handshake from k with req_lock_i[k]=0 releases the lock. The pointer becomes k and normal round-robin resumes.
  - Reset clears the lock.
- Undefined: port req_lock_i is absent, the LOCKED state does not exist, and behaviour is exactly as above.

Decomposition:
- Shared package iob_reg_rr_arbiter_pkg holds:
  - FSM state encoding (EMPTY=2'd0, FULL=2'd1, LOCKED=2'd2).
  - Function clog2 and function onehot2bin.
- One sub-module, iob_rr_pick: combinational circular priority finder.
  - Inputs: req vector and pointer.
  - Outputs: winner index and found flag.
- All state registers use the team's iob_reg_r (enable plus soft reset) primitives.

Test Plan:
Configuration for all scenarios: N_REQ=4, DATA_W=8, ID_W=2.
- Reset: arst_n_i low, then release, with req_valid_i=4'b0000 -> out_valid_o=0, grant_o=0, req_ready_o=0.
- Rotation:
  - Stimulus: req_valid_i=4'b1111 with data 0x10,0x11,0x12,0x13; out_ready_i=1.
  - Response: out_id_o sequence 0,1,2,3,0; out_data_o 0x10,0x11,0x12,0x13,0x10, one beat per cycle.
- Backpressure:
  - Stimulus: accept req 2 (0xA2), then hold out_ready_i=0 for 5 cycles.
  - Response: out_data_o=0xA2 and out_valid_o=1 stable; req_ready_o=0 throughout.
  - After release: next winner is 3 if valid.
- Wrap:
  - Stimulus: pointer at 3 (last grant id 3), req_valid_i=4'b0101.
  - Response: winner id 0, then id 2.
- cke/soft reset:
  - Stimulus: cke_i=0 for 3 cycles with all valid.
  - Response: no handshakes, outputs frozen.
  - Stimulus: then rst_i=1 with cke_i=1.
  - Response: out_valid_o=0 next cycle; the pending beat is dropped.
- Lock (macro defined):
  - Stimulus: req 1 locks for 3 beats (lock=1,1,0) while reqs 0, 2 and 3 are valid.
  - Response: ids 1,1,1, then 2,3,0.
